// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so the increment wraps on its own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output tx_state_t                     dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
  // tx_ready depends only on registered occupancy, and the producer holds
  // tx_data stable while tx_valid is high and tx_ready is low.
  tx_state_t     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          baud_last, pop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready  = !fifo_full;
  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign dbg_state = state_q;
  assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end
      end
      START: if (baud_last) begin
        baud_d  = '0;
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (baud_last) begin
        baud_d  = '0;
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) begin
        baud_d  = '0;
        state_d = STOP;
      end
`endif
      // Popping on the last stop cycle lets the next start bit follow with no gap.
      STOP: if (baud_last) begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign parity_d = pop ? ^fifo_rdata : parity_q;
`endif

  // txd follows the current state, so the line lags the state by one cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = parity_q;
`endif
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, txd, busy;
  logic [2:0] fifo_count;
  tx_state_t  dbg_state;

  int total = 0;
  int bad   = 0;
  int max_count = 0;
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a start bit, then checks every cycle of one frame against the queue head.
  task automatic check_frame(input string tag, input bit no_gap);
    int n = 0;
    logic [7:0] b;
    logic e;
    while (txd !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk(32'(n < 300), 32'd1, {tag, "_start_seen"});
    if (n >= 300) return;
    if (no_gap) chk(n, 0, {tag, "_no_gap"});
    chk(32'(exp_q.size() != 0), 32'd1, {tag, "_expected_byte"});
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)                 e = 1'b0;
      else if (k <= 8)            e = b[k-1];
      else if (k == 9 && NBITS == 11) e = ^b;
      else                        e = 1'b1;
      for (int j = 0; j < C; j++) begin
        chk(32'(txd), 32'(e), $sformatf("%s_byte%02h_bit%0d", tag, b, k));
        tick();
      end
    end
  endtask

  // Holds each byte on tx_valid until it is accepted; accepted bytes go to the scoreboard.
  task automatic drive_stream(input int n, input int mul, input int add, input string tag);
    int prev;
    int step;
    for (int i = 0; i < n; i++) begin
      logic acc;
      int guard = 0;
      tx_valid = 1'b1;
      tx_data  = 8'(i * mul + add);
      do begin
        acc  = tx_ready;
        prev = int'(fifo_count);
        tick();
        guard++;
        step = int'(fifo_count) - prev;
        chk(32'(tx_ready), 32'(fifo_count != 3'd4), {tag, "_ready_vs_count"});
        chk(32'(step >= -1 && step <= 1), 32'd1, {tag, "_count_step"});
        if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
      end while (!acc && guard < 400);
      chk(32'(acc), 32'd1, {tag, "_accept"});
      if (acc) exp_q.push_back(8'(i * mul + add));
    end
    tx_valid = 1'b0;
  endtask

  initial begin
    int zeros;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk(32'(txd), 1, "reset_txd");
    chk(32'(tx_ready), 1, "reset_ready");
    chk(32'(busy), 0, "reset_busy");
    chk(32'(fifo_count), 0, "reset_count");
    chk(32'(dbg_state), 32'(IDLE), "reset_state");

    // Single byte 0x55: accept, START one edge later, txd low the edge after
    tx_valid = 1'b1; tx_data = 8'h55;
    tick();
    tx_valid = 1'b0;
    chk(32'(fifo_count), 1, "single_count_after_accept");
    chk(32'(busy), 1, "single_busy_after_accept");
    chk(32'(txd), 1, "single_txd_n");
    tick();
    chk(32'(dbg_state), 32'(START), "single_state_n1");
    chk(32'(fifo_count), 0, "single_count_n1");
    chk(32'(txd), 1, "single_txd_n1");
    tick();
    chk(32'(txd), 0, "single_txd_n2");
    exp_q.push_back(8'h55);
    check_frame("single", 1'b1);
    chk(32'(busy), 0, "single_busy_end");
    chk(32'(dbg_state), 32'(IDLE), "single_state_end");
    tick();
    chk(32'(txd), 1, "single_idle_line");

    // Burst of three on consecutive cycles: peak occupancy 2, contiguous frames
    tx_valid = 1'b1; tx_data = 8'h01; tick();
    tx_data = 8'h80; tick();
    tx_data = 8'hFF; tick();
    tx_valid = 1'b0;
    chk(32'(fifo_count), 2, "burst_peak_count");
    exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
    check_frame("burst0", 1'b1);
    check_frame("burst1", 1'b1);
    check_frame("burst2", 1'b1);
    chk(32'(fifo_count), 0, "burst_count_end");
    chk(32'(busy), 0, "burst_busy_end");

    // Overflow: 0x00..0x09 held on tx_valid into a depth-4 FIFO
    max_count = 0;
    fork
      drive_stream(10, 1, 0, "ovf");
      for (int k = 0; k < 10; k++) check_frame("ovf", k != 0);
    join
    chk(32'(max_count), 4, "ovf_max_count");
    chk(32'(exp_q.size()), 0, "ovf_queue_drained");
    chk(32'(fifo_count), 0, "ovf_count_end");
    chk(32'(busy), 0, "ovf_busy_end");

    // Pointer wrap: 20 bytes through depth 4
    fork
      drive_stream(20, 37, 5, "wrap");
      for (int k = 0; k < 20; k++) check_frame("wrap", k != 0);
    join
    chk(32'(exp_q.size()), 0, "wrap_queue_drained");
    chk(32'(busy), 0, "wrap_busy_end");

    // Reset during data bit 3 of 0xA5 with 0x11 still queued
    tx_valid = 1'b1; tx_data = 8'hA5; tick();
    tx_data = 8'h11; tick();
    tx_valid = 1'b0;
    tick();
    chk(32'(txd), 0, "rst_start_bit");
    repeat (17) tick();
    chk(32'(txd), 0, "rst_inside_bit3");
    chk(32'(fifo_count), 1, "rst_pending_count");
    rst = 1'b1;
    tick();
    chk(32'(txd), 1, "rst_txd");
    chk(32'(fifo_count), 0, "rst_count");
    chk(32'(busy), 0, "rst_busy");
    chk(32'(tx_ready), 1, "rst_ready");
    rst = 1'b0;
    exp_q.delete();
    zeros = 0;
    repeat (50) begin
      tick();
      if (txd !== 1'b1) zeros++;
    end
    chk(zeros, 0, "rst_no_resume");
    tx_valid = 1'b1; tx_data = 8'h3C; tick();
    tx_valid = 1'b0;
    tick(); tick();
    chk(32'(txd), 0, "post_rst_latency");
    exp_q.push_back(8'h3C);
    check_frame("post_rst", 1'b1);
    chk(32'(busy), 0, "post_rst_busy_end");

`ifdef UART_TX_PARITY_EN
    // Parity: 0x07 has three ones (bit 1), 0x03 has two (bit 0); 44-cycle frames
    tx_valid = 1'b1; tx_data = 8'h07; tick();
    tx_data = 8'h03; tick();
    tx_valid = 1'b0;
    exp_q.push_back(8'h07); exp_q.push_back(8'h03);
    check_frame("par07", 1'b0);
    check_frame("par03", 1'b1);
    chk(32'(busy), 0, "par_busy_end");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
